adc_uart_framer: RTL and testbench

ADC_UART_FRAMER -- requirements
Module: adc_uart_framer

---
 rtl/framer_pkg.sv | 58 +++++
 rtl/period_timer.sv | 37 +++
 rtl/adc_uart_framer.sv | 154 +++++++++++++++
 tb/tb_adc_uart_framer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/framer_pkg.sv
// Shared definitions for the ADC-to-UART framer: FSM state encoding,
// frame length and the 16-byte frame template (marker bytes and the
// positions where the channel snapshots are inserted).
package framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

  localparam int unsigned FRAME_LEN = 16;
  localparam int unsigned IDX_W     = 4;

  // Where a frame byte comes from: a fixed marker or a channel nibble/byte.
  typedef enum logic [2:0] {
    SL_CONST = 3'd0,
    SL_C1_HI = 3'd1,
    SL_C1_LO = 3'd2,
    SL_C2_HI = 3'd3,
    SL_C2_LO = 3'd4
  } slot_e;

  typedef struct packed {
    slot_e      slot;
    logic [7:0] mark;
  } tmpl_t;

  // Frame template: FF 00 00 FF c1h c1l FF 00 00 00 00 FF c2h c2l FF 00
  function automatic tmpl_t frame_tmpl(input logic [IDX_W-1:0] idx);
    frame_tmpl = '{slot: SL_CONST, mark: 8'h00};
    case (idx)
      4'd0, 4'd3, 4'd6, 4'd11, 4'd14: frame_tmpl.mark = 8'hFF;
      4'd4:  frame_tmpl.slot = SL_C1_HI;
      4'd5:  frame_tmpl.slot = SL_C1_LO;
      4'd12: frame_tmpl.slot = SL_C2_HI;
      4'd13: frame_tmpl.slot = SL_C2_LO;
      default: ;
    endcase
  endfunction

  // Resolve the template entry at idx against the captured channel values.
  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                            input logic [11:0] c1,
                                            input logic [11:0] c2);
    tmpl_t t;
    t = frame_tmpl(idx);
    case (t.slot)
      SL_C1_HI: frame_byte = {4'h0, c1[11:8]};
      SL_C1_LO: frame_byte = c1[7:0];
      SL_C2_HI: frame_byte = {4'h0, c2[11:8]};
      SL_C2_LO: frame_byte = c2[7:0];
      default:  frame_byte = t.mark;
    endcase
  endfunction

endpackage

// File: rtl/period_timer.sv
// Saturating 32-bit up-counter used to pace frames. Counts while en is
// high, holds at TC, and clears whenever en drops. tc is high while the
// count sits at TC, so a caller that cannot leave yet keeps seeing it.
module period_timer #(
  parameter logic [31:0] TC = 32'd99_999_999
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tc
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next count: clear when disabled, increment until terminal count.
  always_comb begin
    count_d = count_q;
    if (!en) begin
      count_d = 32'd0;
    end else if (count_q != TC) begin
      count_d = count_q + 32'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = en && (count_q == TC);

endmodule

// File: rtl/adc_uart_framer.sv
// Periodically snapshots two 12-bit ADC channels and streams them as a
// fixed 16-byte frame over a valid/ready byte interface to a UART TX.
// Optional feature macro FRAMER_ECHO_EN: while idle between frames,
// bytes from the UART RX are echoed back to the transmitter.
//
// state | meaning
// IDLE  | just out of reset, go to LOAD next cycle
// LOAD  | capture channel values, clear byte index
// SEND  | stream frame bytes, one idle cycle after each transfer
// WAIT  | pace until the next period (echo rx bytes if enabled)
module adc_uart_framer
  import framer_pkg::*;
#(
  parameter int CLK_FRE   = 100,
  parameter int PERIOD_MS = 1000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] volt_ch1,
  input  logic [15:0] volt_ch2,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        tx_data_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_valid,
  output logic        rx_data_ready,
  output logic        frame_busy
);

  localparam logic [31:0] PERIOD_TC = 32'(CLK_FRE * 1000 * PERIOD_MS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [11:0]      ch1_q, ch1_d;
  logic [11:0]      ch2_q, ch2_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;

  logic wait_en;
  logic period_tc;
  logic tx_fire;
  logic rx_ready;
  logic rx_fire;

  logic unused_volt;
  assign unused_volt = ^{volt_ch1[15:12], volt_ch2[15:12]};

  assign tx_fire = tx_valid_q && tx_data_ready;
  assign wait_en = (state_q == ST_WAIT);

`ifdef FRAMER_ECHO_EN
  // Accept an rx byte only between frames and when the tx slot is free.
  assign rx_ready = (state_q == ST_WAIT) && !tx_valid_q;
  assign rx_fire  = rx_data_valid && rx_ready;
`else
  logic unused_rx;
  assign unused_rx = ^{rx_data, rx_data_valid};
  assign rx_ready  = 1'b0;
  assign rx_fire   = 1'b0;
`endif

  period_timer #(
    .TC (PERIOD_TC)
  ) u_period_timer (
    .clk (sys_clk),
    .rst (sys_rst),
    .en  (wait_en),
    .tc  (period_tc)
  );

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a pending or just-accepted echo holds off the next frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_LOAD;
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: if (tx_fire && (idx_q == LAST_IDX)) state_d = ST_WAIT;
      ST_WAIT: if (period_tc && !tx_valid_q && !rx_fire) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: snapshots, byte index and the tx holding register.
  always_comb begin
    idx_d      = idx_q;
    ch1_d      = ch1_q;
    ch2_d      = ch2_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      ST_LOAD: begin
        ch1_d = volt_ch1[11:0];
        ch2_d = volt_ch2[11:0];
        idx_d = '0;
      end
      ST_SEND: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          idx_d      = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end else if (!tx_valid_q) begin
          // Reached only on the cycle after a transfer (or on entry), which
          // gives the single idle cycle between bytes.
          tx_valid_d = 1'b1;
          tx_data_d  = frame_byte(idx_q, ch1_q, ch2_q);
        end
      end
      ST_WAIT: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
        end else if (rx_fire) begin
          tx_valid_d = 1'b1;
          tx_data_d  = rx_data;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      idx_q      <= '0;
      ch1_q      <= '0;
      ch2_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      ch1_q      <= ch1_d;
      ch2_q      <= ch2_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Outputs decoded from state and registers.
  always_comb begin
    frame_busy    = (state_q == ST_LOAD) || (state_q == ST_SEND);
    tx_data       = tx_data_q;
    tx_data_valid = tx_valid_q;
    rx_data_ready = rx_ready;
  end

endmodule

// File: tb/tb_adc_uart_framer.sv
// Directed bench for adc_uart_framer with a 1000-cycle frame period.
module tb_adc_uart_framer;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [15:0] volt_ch1;
  logic [15:0] volt_ch2;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        rx_data_ready;
  logic        frame_busy;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  adc_uart_framer #(
    .CLK_FRE   (1),
    .PERIOD_MS (1)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .volt_ch1      (volt_ch1),
    .volt_ch2      (volt_ch2),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .frame_busy    (frame_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [11:0] c1, input logic [11:0] c2);
    case (i)
      0, 3, 6, 11, 14: return 8'hFF;
      4:  return {4'h0, c1[11:8]};
      5:  return c1[7:0];
      12: return {4'h0, c2[11:8]};
      13: return c2[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // Collect n_bytes of a frame. Optional 5-cycle stall at stall_idx and
  // optional change of volt_ch1 once index change_idx is on the bus.
  task automatic collect(input logic [11:0] c1, input logic [11:0] c2, input int n_bytes,
                         input int stall_idx, input int change_idx, input logic [15:0] change_val);
    for (int i = 0; i < n_bytes; i++) begin
      int budget;
      budget = 0;
      while (!tx_data_valid && budget < 3000) begin
        step;
        budget++;
      end
      chk($sformatf("byte%0d_valid", i), tx_data_valid, 1);
      if (i > 0) chk($sformatf("byte%0d_gap_len", i), budget, 1);
      if (i == stall_idx) begin
        tx_data_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          step;
          chk($sformatf("stall%0d_valid", k), tx_data_valid, 1);
          chk($sformatf("stall%0d_data", k), tx_data, exp_byte(i, c1, c2));
        end
        tx_data_ready = 1'b1;
      end
      if (i == change_idx) volt_ch1 = change_val;
      chk($sformatf("byte%0d", i), tx_data, exp_byte(i, c1, c2));
      step;
      chk($sformatf("byte%0d_drop", i), tx_data_valid, 0);
    end
  endtask

  int          cnt;
  int          n_echo;
  logic        rdy_seen;
  logic        acc;
  logic [7:0]  echo_byte;

  initial begin
    volt_ch1      = 16'h0ABC;
    volt_ch2      = 16'h0123;
    tx_data_ready = 1'b1;
    rx_data       = 8'h00;
    rx_data_valid = 1'b0;

    step;
    step;
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_valid", tx_data_valid, 0);
    chk("rst_rx_ready", rx_data_ready, 0);
    chk("rst_busy", frame_busy, 0);

    sys_rst = 1'b0;
    #1;
    chk("idle_busy", frame_busy, 0);
    step;
    chk("idle_to_load", frame_busy, 1);

    // Frame 1: plain streaming with ready held high.
    collect(12'hABC, 12'h123, 16, -1, -1, 16'h0);

    // Idle gap between frames measured in non-busy cycles.
    cnt = 0;
    while (!frame_busy && cnt < 5000) begin
      cnt++;
      step;
    end
    chk("wait_cycles", cnt, 1000);

    // Frame 2: back-pressure at index 4.
    collect(12'hABC, 12'h123, 16, 4, -1, 16'h0);

    // Frame 3 snapshots 0x111; input changes to 0x222 mid-frame.
    volt_ch1 = 16'h0111;
    collect(12'h111, 12'h123, 16, -1, 2, 16'h0222);
    collect(12'h222, 12'h123, 16, -1, -1, 16'h0);

    // Echo window between frames.
    rx_data       = 8'h5A;
    rx_data_valid = 1'b1;
    n_echo        = 0;
    rdy_seen      = 1'b0;
    echo_byte     = 8'h00;
    cnt           = 0;
    while (!frame_busy && cnt < 3000) begin
      acc = rx_data_valid && rx_data_ready;
      if (rx_data_ready) rdy_seen = 1'b1;
      if (tx_data_valid && tx_data_ready) begin
        n_echo++;
        echo_byte = tx_data;
      end
      step;
      cnt++;
      if (acc) rx_data_valid = 1'b0;
    end
    rx_data_valid = 1'b0;
    chk("echo_window_end", frame_busy, 1);
`ifdef FRAMER_ECHO_EN
    chk("echo_count", n_echo, 1);
    chk("echo_byte", echo_byte, 8'h5A);
    chk("echo_rx_ready_seen", rdy_seen, 1);
`else
    chk("echo_count", n_echo, 0);
    chk("echo_rx_ready_seen", rdy_seen, 0);
`endif

    // Frame 5: reset while index 7 is on the bus.
    collect(12'h222, 12'h123, 7, -1, -1, 16'h0);
    cnt = 0;
    while (!tx_data_valid && cnt < 3000) begin
      step;
      cnt++;
    end
    chk("idx7_valid", tx_data_valid, 1);
    chk("idx7_data", tx_data, 8'h00);
    sys_rst = 1'b1;
    #1;
    chk("midrst_tx_data", tx_data, 0);
    chk("midrst_tx_valid", tx_data_valid, 0);
    chk("midrst_rx_ready", rx_data_ready, 0);
    chk("midrst_busy", frame_busy, 0);
    step;
    step;
    sys_rst = 1'b0;

    // Frame after reset restarts from index 0.
    collect(12'h222, 12'h123, 16, -1, -1, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
